// File: rtl/decimal_entry.sv
// Keypad digit entry with sign, then a serial BCD-to-binary conversion (one digit per cycle,
// MS digit first) into a saturated 12-bit two's-complement result held behind valid/ready.
module decimal_entry #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              key_code,
  input  logic                    key_valid,
  input  logic                    out_ready,
  output logic [11:0]             value,
  output logic                    overflow,
  output logic                    out_valid,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] entry_bcd,
  output logic                    entry_neg,
  output logic [2:0]              digit_count
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [2:0]    MAX_CNT  = 3'(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ENTRY, CONVERT, HOLD} state_t;

  state_t        state;
  logic [13:0]   acc;
  logic [IW-1:0] idx;
  logic [3:0]    cur_digit;
  logic [13:0]   acc_next;
  logic [11:0]   sat_value;
  logic          sat_ovf;

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) cur_digit = entry_bcd[i*4 +: 4];
    end
  end

  // acc never exceeds 999 before the last step, so the shifts cannot wrap.
  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, cur_digit};

  always_comb begin
    sat_value = acc_next[11:0];
    sat_ovf   = 1'b0;
    if (!entry_neg) begin
      if (acc_next > 14'd2047) begin
        sat_value = 12'h7FF;
        sat_ovf   = 1'b1;
      end
    end else if (acc_next > 14'd2048) begin
      sat_value = 12'h800;
      sat_ovf   = 1'b1;
    end else begin
      sat_value = ~acc_next[11:0] + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ENTRY;
      acc         <= '0;
      idx         <= '0;
      value       <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      entry_bcd   <= '0;
      entry_neg   <= 1'b0;
      digit_count <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (digit_count != MAX_CNT && !(digit_count == 3'd0 && key_code == 4'd0)) begin
                entry_bcd   <= (entry_bcd << 4) | BW'(key_code);
                digit_count <= digit_count + 3'd1;
              end
            end else begin
              case (key_code)
                4'hA: entry_neg <= ~entry_neg;
                4'hB: begin
                  if (digit_count != 3'd0) begin
                    entry_bcd   <= entry_bcd >> 4;
                    digit_count <= digit_count - 3'd1;
                  end
                end
                4'hC: begin
                  entry_bcd   <= '0;
                  digit_count <= '0;
                  entry_neg   <= 1'b0;
                end
                4'hE: begin
                  state <= CONVERT;
                  acc   <= '0;
                  idx   <= LAST_IDX;
                  busy  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        CONVERT: begin
          acc <= acc_next;
          if (idx == '0) begin
            state     <= HOLD;
            busy      <= 1'b0;
            value     <= sat_value;
            overflow  <= sat_ovf;
            out_valid <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= ENTRY;
            out_valid   <= 1'b0;
            entry_bcd   <= '0;
            digit_count <= '0;
            entry_neg   <= 1'b0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule
